// File: rtl/gmii_frame_gen.sv
// gmii_frame_gen: parametrised GMII frame source.
// Emits preamble, SFD, an incrementing or PRBS8 payload of programmable length,
// then a programmable inter-packet gap. All outputs are registered.
// Optional build macro: GMII_ERR_INJ_EN adds single-byte TX_ER injection at err_pos.
module gmii_frame_gen #(
   parameter int MAX_LEN = 1500,
   parameter int LEN_W   = 11,
   parameter int PRE_LEN = 7,
   parameter int IPG_MIN = 12,
   parameter int IPG_W   = 8,
   parameter int CNT_W   = 16
) (
   input  logic             GTX_CLK,
   input  logic             mr_main_reset,
   input  logic             start,
   input  logic [LEN_W-1:0] frame_len,
   input  logic [IPG_W-1:0] ipg_len,
   input  logic             mode,
   input  logic [7:0]       seed,
   input  logic [LEN_W-1:0] err_pos,
   output logic [7:0]       TXD,
   output logic             TX_EN,
   output logic             TX_ER,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] frame_cnt
);

   // Shared cycle counter must cover payload, IPG and preamble ranges.
   localparam int PW  = $clog2(PRE_LEN + 1);
   localparam int CW0 = (LEN_W > IPG_W) ? LEN_W : IPG_W;
   localparam int CW  = (CW0 > PW) ? CW0 : PW;

   localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
   localparam logic [IPG_W-1:0] IPG_MN  = IPG_W'(IPG_MIN);
   localparam logic [CW-1:0]    ONE     = CW'(1);
   localparam logic [CW-1:0]    PRE_LST = CW'(PRE_LEN - 1);

   typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, IPG} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [LEN_W-1:0] len_r;
   logic [IPG_W-1:0] ipg_r;
   logic             mode_r;
   logic [7:0]       dat_r;     // payload value currently on the wire (pre-injection)

   logic [LEN_W-1:0] len_clamp;
   logic [IPG_W-1:0] ipg_clamp;
   logic [CW-1:0]    len_last;
   logic [CW-1:0]    ipg_last;
   logic [CW-1:0]    cnt_nxt;
   logic [7:0]       dat_nxt;
   logic             inj_first;
   logic             inj_nxt;

   // x^8+x^6+x^5+x^4+1, Fibonacci form, shift left with feedback into bit 0.
   function automatic logic [7:0] lfsr_next(input logic [7:0] q);
      return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
   endfunction

   assign len_clamp = (frame_len > MAX_L) ? MAX_L : frame_len;
   assign ipg_clamp = (ipg_len < IPG_MN) ? IPG_MN : ipg_len;
   assign len_last  = CW'(len_r) - ONE;
   assign ipg_last  = CW'(ipg_r) - ONE;
   assign cnt_nxt   = cnt + ONE;
   assign dat_nxt   = mode_r ? lfsr_next(dat_r) : dat_r + 8'd1;

`ifdef GMII_ERR_INJ_EN
   logic [LEN_W-1:0] err_r;

   // Capture the injection index alongside the other frame parameters.
   always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
      if (!mr_main_reset)
         err_r <= '0;
      else if (state == IDLE && start && frame_len != '0)
         err_r <= err_pos;
   end

   // err_pos beyond the payload never matches an index, so no injection occurs.
   assign inj_first = (err_r == '0);
   assign inj_nxt   = (CW'(err_r) == cnt_nxt);
`else
   logic unused_err;
   assign unused_err = ^err_pos;
   assign inj_first  = 1'b0;
   assign inj_nxt    = 1'b0;
`endif

   // Frame sequencer; each branch sets the outputs seen during the next cycle.
   always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
      if (!mr_main_reset) begin
         state     <= IDLE;
         cnt       <= '0;
         len_r     <= '0;
         ipg_r     <= '0;
         mode_r    <= 1'b0;
         dat_r     <= 8'h00;
         TXD       <= 8'h00;
         TX_EN     <= 1'b0;
         TX_ER     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         frame_cnt <= '0;
      end else begin
         done  <= 1'b0;
         TX_ER <= 1'b0;
         case (state)
            IDLE: begin
               TXD   <= 8'h00;
               TX_EN <= 1'b0;
               busy  <= 1'b0;
               if (start && frame_len != '0) begin
                  len_r  <= len_clamp;
                  ipg_r  <= ipg_clamp;
                  mode_r <= mode;
                  // An all-zero LFSR would lock up, so PRBS mode starts at 01.
                  dat_r  <= (mode && seed == 8'h00) ? 8'h01 : seed;
                  cnt    <= '0;
                  TXD    <= 8'h55;
                  TX_EN  <= 1'b1;
                  busy   <= 1'b1;
                  state  <= PRE;
               end
            end
            PRE: begin
               if (cnt == PRE_LST) begin
                  TXD   <= 8'hD5;
                  state <= SFD;
               end else begin
                  cnt <= cnt_nxt;
                  TXD <= 8'h55;
               end
            end
            SFD: begin
               cnt   <= '0;
               TXD   <= inj_first ? 8'hFE : dat_r;
               TX_ER <= inj_first;
               state <= DATA;
            end
            DATA: begin
               if (cnt == len_last) begin
                  cnt   <= '0;
                  TXD   <= 8'h00;
                  TX_EN <= 1'b0;
                  state <= IPG;
                  if (ipg_last == '0) begin
                     done      <= 1'b1;
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end else begin
                  // The generator advances even over an injected byte.
                  cnt   <= cnt_nxt;
                  dat_r <= dat_nxt;
                  TXD   <= inj_nxt ? 8'hFE : dat_nxt;
                  TX_ER <= inj_nxt;
               end
            end
            IPG: begin
               TXD   <= 8'h00;
               TX_EN <= 1'b0;
               if (cnt == ipg_last) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt_nxt;
                  if (cnt_nxt == ipg_last) begin
                     done      <= 1'b1;
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
            end
            default: begin
               TXD   <= 8'h00;
               TX_EN <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
